// File: rtl/obi_fair_responder_if.sv
// Core-side OBI bus bundle for the fair responder, one lane per channel.
// Channel c occupies bit c of the scalar vectors and slice
// [c*W +: W] of the address and data vectors.
interface obi_fair_responder_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req_i;
    logic [NUM_CH-1:0]        we_i;
    logic [NUM_CH*ADDR_W-1:0] addr_i;
    logic [NUM_CH-1:0]        gnt_o;
    logic [NUM_CH-1:0]        rvalid_o;
    logic [NUM_CH*DATA_W-1:0] rdata_o;

    // core side drives requests and consumes grants and responses
    modport master (
        output req_i, we_i, addr_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    // responder side
    modport slave (
        input  req_i, we_i, addr_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/obi_fair_responder.sv
// Multi-channel OBI memory responder for formal core wrappers.
// Free solver inputs (rand_*) propose grants and responses. The responder
// filters them into protocol-legal behaviour: no grant without a request,
// no response without an outstanding request, and bounded stalls on both.
// It also raises a sticky flag when the core drops or changes a request
// before that request has been granted.
// Channel 0 is instruction fetch and channel 1 is data. The channels are
// fully independent of each other.
module obi_fair_responder #(
    parameter int  NUM_CH           = 2,
    parameter int  ADDR_W           = 32,
    parameter int  DATA_W           = 32,
    parameter int  MAX_OUTSTANDING  = 2,
    parameter int  MAX_GNT_STALL    = 3,
    parameter int  MAX_RVALID_STALL = 3,
    localparam int OW               = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    obi_fair_responder_if.slave      bus,
    input  logic [NUM_CH-1:0]        rand_gnt_i,
    input  logic [NUM_CH-1:0]        rand_rvalid_i,
    input  logic [NUM_CH*DATA_W-1:0] rand_rdata_i,
    output logic [NUM_CH*OW-1:0]     outstanding_o,
    output logic [NUM_CH-1:0]        proto_err_o
);

    // Stall counters need at least one bit, even when the stall limit is 0.
    localparam int GSW = (MAX_GNT_STALL > 0) ? $clog2(MAX_GNT_STALL + 1) : 1;
    localparam int RSW = (MAX_RVALID_STALL > 0) ? $clog2(MAX_RVALID_STALL + 1) : 1;

    localparam logic [OW-1:0]  OUT_MAX = OW'(MAX_OUTSTANDING);
    localparam logic [GSW-1:0] GST_MAX = GSW'(MAX_GNT_STALL);
    localparam logic [RSW-1:0] RST_MAX = RSW'(MAX_RVALID_STALL);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [OW-1:0]     out_cnt;
        logic [GSW-1:0]    gnt_stall;
        logic [RSW-1:0]    rv_stall;
        logic              held_req;
        logic              held_we;
        logic [ADDR_W-1:0] held_addr;
        logic              err;

        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic              full;
        logic              gnt;
        logic              rvalid;
        logic              breach;

        assign req  = bus.req_i[c];
        assign we   = bus.we_i[c];
        assign addr = bus.addr_i[c*ADDR_W +: ADDR_W];

        // Filter the candidate grant and response. Only the registered count
        // is used to decide "full", so a response in this cycle never makes
        // room for a grant in the same cycle.
        always_comb begin
            full   = (out_cnt == OUT_MAX);
            gnt    = !reset && req && !full &&
                     (rand_gnt_i[c] || (gnt_stall == GST_MAX));
            rvalid = !reset && (out_cnt != '0) &&
                     (rand_rvalid_i[c] || (rv_stall == RST_MAX));
            breach = held_req && (!req || (addr != held_addr) || (we != held_we));
        end

        assign bus.gnt_o[c]                       = gnt;
        assign bus.rvalid_o[c]                    = rvalid;
        assign bus.rdata_o[c*DATA_W +: DATA_W]    = rvalid ? rand_rdata_i[c*DATA_W +: DATA_W] : '0;
        assign outstanding_o[c*OW +: OW]          = out_cnt;
        assign proto_err_o[c]                     = err;

        // Per-channel bookkeeping: outstanding count, stall timers, request tracking and the sticky error.
        always_ff @(posedge clock) begin
            if (reset) begin
                out_cnt   <= '0;
                gnt_stall <= '0;
                rv_stall  <= '0;
                held_req  <= 1'b0;
                held_we   <= 1'b0;
                held_addr <= '0;
                err       <= 1'b0;
            end else begin
                case ({gnt, rvalid})
                    2'b10:   out_cnt <= out_cnt + OW'(1);
                    2'b01:   out_cnt <= out_cnt - OW'(1);
                    default: out_cnt <= out_cnt;
                endcase

                // While full, the timer saturates and holds, so the forced grant
                // fires as soon as a slot frees up.
                if (!req || gnt) begin
                    gnt_stall <= '0;
                end else if (gnt_stall != GST_MAX) begin
                    gnt_stall <= gnt_stall + GSW'(1);
                end

                if ((out_cnt == '0) || rvalid) begin
                    rv_stall <= '0;
                end else if (rv_stall != RST_MAX) begin
                    rv_stall <= rv_stall + RSW'(1);
                end

                held_req  <= req && !gnt;
                held_addr <= addr;
                held_we   <= we;
                if (breach) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_obi_fair_responder.sv
// Bench for obi_fair_responder with the default parameters:
// 2 channels, 32-bit address and data, 2 outstanding requests and 3-cycle stall limits.
// Each driven cycle pushes its hand-derived expected outputs to a queue.
// A monitor on the falling edge pops them and compares them with the DUT outputs.
module tb_obi_fair_responder;

    localparam int OW = 2;

    logic clock = 1'b0;
    logic reset;
    logic [1:0]  rand_gnt;
    logic [1:0]  rand_rvalid;
    logic [63:0] rand_rdata;
    logic [3:0]  outstanding;
    logic [1:0]  proto_err;

    obi_fair_responder_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus ();

    obi_fair_responder dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .rand_gnt_i    (rand_gnt),
        .rand_rvalid_i (rand_rvalid),
        .rand_rdata_i  (rand_rdata),
        .outstanding_o (outstanding),
        .proto_err_o   (proto_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic [63:0] rdata;
        logic [3:0]  outst;
        logic [1:0]  err;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // staged stimulus, applied at the start of the next driven cycle
    logic        s_rst;
    logic [1:0]  s_req;
    logic [1:0]  s_we;
    logic [63:0] s_addr;
    logic [1:0]  s_rg;
    logic [1:0]  s_rv;
    logic [63:0] s_rd;

    localparam logic [63:0] RD_A = {32'h1111_1111, 32'hCAFE_F00D};
    localparam logic [63:0] EL_A = {32'h0, 32'hCAFE_F00D};
    localparam logic [63:0] RD_B = {32'h2222_2222, 32'hDEAD_BEEF};
    localparam logic [63:0] EL_B = {32'h0, 32'hDEAD_BEEF};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic drive(input string tag, input logic [1:0] g, input logic [1:0] v,
                         input logic [63:0] d, input logic [3:0] o, input logic [1:0] e);
        exp_t x;
        @(posedge clock);
        #2;
        reset       = s_rst;
        bus.req_i   = s_req;
        bus.we_i    = s_we;
        bus.addr_i  = s_addr;
        rand_gnt    = s_rg;
        rand_rvalid = s_rv;
        rand_rdata  = s_rd;
        x.tag = tag; x.gnt = g; x.rv = v; x.rdata = d; x.outst = o; x.err = e;
        exp_q.push_back(x);
    endtask

    // compare the outputs of each driven cycle mid-cycle, away from the rising edge
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk({x.tag, ".gnt"},   64'(bus.gnt_o),    64'(x.gnt));
            chk({x.tag, ".rv"},    64'(bus.rvalid_o), 64'(x.rv));
            chk({x.tag, ".rdata"}, bus.rdata_o,       x.rdata);
            chk({x.tag, ".outst"}, 64'(outstanding),  64'(x.outst));
            chk({x.tag, ".err"},   64'(proto_err),    64'(x.err));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        s_rst = 1'b1; s_req = 2'b00; s_we = 2'b00;
        s_addr = {32'h0, 32'h40}; s_rg = 2'b11; s_rv = 2'b11; s_rd = RD_A;
        reset = 1'b1; bus.req_i = 2'b00; bus.we_i = 2'b00; bus.addr_i = s_addr;
        rand_gnt = 2'b11; rand_rvalid = 2'b11; rand_rdata = RD_A;

        // reset with every candidate input high: all outputs quiet
        drive("rst0", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);
        drive("rst1", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);
        s_rst = 1'b0; s_rg = 2'b00; s_rv = 2'b00;
        drive("idle", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);

        // forced grant on the 4th cycle of the request, then forced rvalid 4 cycles later
        s_req = 2'b01;
        for (int i = 0; i < 3; i++) drive("gstall", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);
        drive("gforce", 2'b01, 2'b00, 64'h0, 4'd0, 2'b00);
        s_req = 2'b00;
        for (int i = 0; i < 3; i++) drive("rstall", 2'b00, 2'b00, 64'h0, 4'd1, 2'b00);
        drive("rforce", 2'b00, 2'b01, EL_A, 4'd1, 2'b00);
        drive("drain", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);

        // fill to the outstanding limit, then a forced response frees a slot
        s_req = 2'b01; s_rg = 2'b01;
        drive("o_c0", 2'b01, 2'b00, 64'h0, 4'd0, 2'b00);
        drive("o_c1", 2'b01, 2'b00, 64'h0, 4'd1, 2'b00);
        drive("o_full", 2'b00, 2'b00, 64'h0, 4'd2, 2'b00);
        drive("o_full", 2'b00, 2'b00, 64'h0, 4'd2, 2'b00);
        drive("o_rv", 2'b00, 2'b01, EL_A, 4'd2, 2'b00);
        drive("o_free", 2'b01, 2'b00, 64'h0, 4'd1, 2'b00);
        s_req = 2'b00; s_rg = 2'b00; s_rv = 2'b01;
        drive("o_d0", 2'b00, 2'b01, EL_A, 4'd2, 2'b00);
        drive("o_d1", 2'b00, 2'b01, EL_A, 4'd1, 2'b00);
        s_rv = 2'b00;
        drive("o_d2", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);

        // grant and response in the same cycle leave the count unchanged
        s_req = 2'b01; s_rg = 2'b01;
        drive("b_g", 2'b01, 2'b00, 64'h0, 4'd0, 2'b00);
        s_rv = 2'b01; s_rd = RD_B;
        drive("b_both", 2'b01, 2'b01, EL_B, 4'd1, 2'b00);
        s_req = 2'b00; s_rg = 2'b00; s_rv = 2'b00;
        drive("b_hold", 2'b00, 2'b00, 64'h0, 4'd1, 2'b00);
        s_rv = 2'b01;
        drive("b_rv", 2'b00, 2'b01, EL_B, 4'd1, 2'b00);
        s_rv = 2'b00; s_rd = RD_A;
        drive("b_end", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);

        // channel 1 changes its address while still waiting for a grant
        s_req = 2'b10; s_addr = {32'h100, 32'h40};
        drive("p_a", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);
        s_addr = {32'h104, 32'h40};
        drive("p_b", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);
        s_req = 2'b00;
        drive("p_err", 2'b00, 2'b00, 64'h0, 4'd0, 2'b10);
        s_addr = {32'h0, 32'h40};
        drive("p_stk", 2'b00, 2'b00, 64'h0, 4'd0, 2'b10);

        // reset with two requests outstanding drops them
        s_req = 2'b01; s_rg = 2'b01;
        drive("x_g0", 2'b01, 2'b00, 64'h0, 4'd0, 2'b10);
        drive("x_g1", 2'b01, 2'b00, 64'h0, 4'd1, 2'b10);
        s_rst = 1'b1; s_rg = 2'b11; s_rv = 2'b11;
        drive("x_rst", 2'b00, 2'b00, 64'h0, 4'd2, 2'b10);
        s_rst = 1'b0; s_req = 2'b00;
        drive("x_post", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);
        drive("x_post2", 2'b00, 2'b00, 64'h0, 4'd0, 2'b00);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
